// File: rtl/v810_bus_pkg.sv
// Shared types and constants for the v810 external bus cycle controller.
package v810_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } bus_st_t;

    localparam logic [31:0] UNMAPPED_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/v810_bus_decode.sv
// Address region decoder: region r hits when (A & MASK[r]) == MATCH[r];
// the lowest-index hit wins, so the hit vector is one-hot or zero.
module v810_bus_decode #(
    parameter int unsigned        NREG  = 3,
    parameter logic [NREG*32-1:0] MATCH = {NREG{32'h0}},
    parameter logic [NREG*32-1:0] MASK  = {NREG{32'h0}}
) (
    input  logic [31:0]     i_addr,
    output logic [NREG-1:0] o_hit,
    output logic            o_hit_valid
);

    logic w_found;

    always_comb begin
        o_hit   = '0;
        w_found = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (!w_found && ((i_addr & MASK[r*32 +: 32]) == MATCH[r*32 +: 32])) begin
                o_hit[r] = 1'b1;
                w_found  = 1'b1;
            end
        end
        o_hit_valid = w_found;
    end

endmodule

// File: rtl/v810_bus_ctrl.sv
// v810 external bus cycle controller: region decode, programmable wait states,
// chip-enable/strobe generation and registered read-data steering.
module v810_bus_ctrl
    import v810_bus_pkg::*;
#(
    parameter int unsigned        NREG  = 3,
    parameter logic [NREG*32-1:0] MATCH = {NREG{32'h0}},
    parameter logic [NREG*32-1:0] MASK  = {NREG{32'h0}},
    parameter int unsigned        WSW   = 4
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                CE,
    input  logic [31:0]         A,
    input  logic [3:0]          BEn,
    input  logic                DAn,
    input  logic                MRQn,
    input  logic                RW,
    input  logic                BCYSTn,
    output logic                READYn,
    output logic                SZRQn,
    output logic [31:0]         D_I,
    output logic                ERR,
    input  logic [NREG*WSW-1:0] CFG_WS,
    input  logic [NREG-1:0]     CFG_W16,
    output logic [NREG-1:0]     CEn,
    output logic                WEn,
    output logic                OEn,
    input  logic [NREG*32-1:0]  RD
);

    localparam logic [WSW-1:0] CNT_ONE = WSW'(1);

    bus_st_t         r_state, w_state_nxt;
    logic [WSW-1:0]  r_cnt, w_cnt_nxt;
    logic [NREG-1:0] r_sel, w_sel_nxt;
    logic            r_w16, w_w16_nxt;
    logic            r_err, w_err_nxt;
    logic [31:0]     r_di, w_di_nxt;

    logic [NREG-1:0] w_hit;
    logic            w_hit_valid;
    logic [WSW-1:0]  w_hit_ws;
    logic            w_hit_w16;
    logic [31:0]     w_hit_rd;
    logic [31:0]     w_sel_rd;
    logic            w_active;
    logic            w_region_act;
    logic            w_unused;

    // IO space (MRQn=1) decodes like memory; byte lanes are the memories' concern.
    assign w_unused = &{1'b0, BEn, MRQn};

    v810_bus_decode #(
        .NREG  (NREG),
        .MATCH (MATCH),
        .MASK  (MASK)
    ) u_decode (
        .i_addr      (A),
        .o_hit       (w_hit),
        .o_hit_valid (w_hit_valid)
    );

    always_comb begin
        w_hit_ws  = '0;
        w_hit_w16 = 1'b0;
        w_hit_rd  = '0;
        w_sel_rd  = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (w_hit[r]) begin
                w_hit_ws  = w_hit_ws | CFG_WS[r*WSW +: WSW];
                w_hit_w16 = w_hit_w16 | CFG_W16[r];
                w_hit_rd  = w_hit_rd | RD[r*32 +: 32];
            end
            if (r_sel[r]) begin
                w_sel_rd = w_sel_rd | RD[r*32 +: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_w16_nxt   = r_w16;
        w_err_nxt   = 1'b0;
        w_di_nxt    = r_di;
        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                // DONE accepts a new start directly so back-to-back cycles have no bubble.
                if (!BCYSTn) begin
                    w_sel_nxt = w_hit;
                    w_w16_nxt = w_hit_valid & w_hit_w16;
                    w_cnt_nxt = w_hit_ws;
                    if (!w_hit_valid) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_di_nxt    = UNMAPPED_DATA;
                    end else if (w_hit_ws != '0) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = DONE;
                        w_di_nxt    = w_hit_rd;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = DONE;
                    w_di_nxt    = w_sel_rd;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_w16   <= 1'b0;
            r_err   <= 1'b0;
            r_di    <= UNMAPPED_DATA;
        end else if (CE) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_w16   <= w_w16_nxt;
            r_err   <= w_err_nxt;
            r_di    <= w_di_nxt;
        end
    end

    assign w_active     = (r_state != IDLE);
    assign w_region_act = w_active & (|r_sel);
    assign READYn       = ~(r_state == DONE);
    assign SZRQn        = ~((r_state == DONE) & r_w16);
    assign CEn          = w_active ? ~r_sel : '1;
    assign WEn          = ~(w_region_act & ~RW & ~DAn);
    assign OEn          = ~(w_region_act & RW & ~DAn);
    assign D_I          = r_di;
    assign ERR          = r_err;

    a_no_start_in_wait: assert property (
        @(posedge CLK) disable iff (RES) (CE && (r_state == WAIT)) |-> BCYSTn
    );

endmodule

// File: tb/tb_v810_bus_ctrl.sv
// Self-checking bench for v810_bus_ctrl: directed scenarios plus randomized
// chained transactions checked against a per-cycle reference model.
module tb_v810_bus_ctrl;

    localparam int unsigned NREG = 3;
    localparam int unsigned WSW  = 4;
    localparam int unsigned CW   = NREG * WSW;
    localparam logic [31:0] UNMAPPED = 32'hFFFF_FFFF;

    // Region 0: 0000_0000-0000_FFFF, region 1: 1xxx_xxxx, region 2: 0000_0000-3FFF_FFFF.
    localparam logic [NREG*32-1:0] P_MATCH = {32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NREG*32-1:0] P_MASK  = {32'hC000_0000, 32'hF000_0000, 32'hFFFF_0000};
    localparam logic [31:0] REG_LO [NREG] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [31:0] REG_HI [NREG] = '{32'h0000_FFFF, 32'h1FFF_FFFF, 32'h3FFF_FFFF};

    typedef struct {
        logic [31:0]     addr;
        logic            rw;
        logic [CW-1:0]   ws;
        logic [NREG-1:0] w16;
    } txn_t;

    logic              CLK = 1'b0;
    logic              RES, CE, DAn, MRQn, RW, BCYSTn;
    logic [31:0]       A;
    logic [3:0]        BEn;
    logic              READYn, SZRQn, ERR, WEn, OEn;
    logic [31:0]       D_I;
    logic [CW-1:0]     CFG_WS;
    logic [NREG-1:0]   CFG_W16;
    logic [NREG-1:0]   CEn;
    logic [NREG*32-1:0] RD;
    logic [31:0]       rd_val [NREG];

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_di;
    txn_t seq_q[$];
    int seq_cycles, seq_ready, seq_wen_low, seq_err, seq_szrq, seq_first_ready;

    always #5 CLK = ~CLK;

    always_comb begin
        RD = '0;
        for (int r = 0; r < NREG; r++) RD[r*32 +: 32] = rd_val[r];
    end

    v810_bus_ctrl #(
        .NREG  (NREG),
        .MATCH (P_MATCH),
        .MASK  (P_MASK),
        .WSW   (WSW)
    ) dut (
        .CLK     (CLK),
        .RES     (RES),
        .CE      (CE),
        .A       (A),
        .BEn     (BEn),
        .DAn     (DAn),
        .MRQn    (MRQn),
        .RW      (RW),
        .BCYSTn  (BCYSTn),
        .READYn  (READYn),
        .SZRQn   (SZRQn),
        .D_I     (D_I),
        .ERR     (ERR),
        .CFG_WS  (CFG_WS),
        .CFG_W16 (CFG_W16),
        .CEn     (CEn),
        .WEn     (WEn),
        .OEn     (OEn),
        .RD      (RD)
    );

    function automatic int region_of(input logic [31:0] a);
        for (int r = 0; r < NREG; r++)
            if (a >= REG_LO[r] && a <= REG_HI[r]) return r;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 3))
            0: a[31:16] = '0;
            1: a[31:28] = 4'h1;
            2: a[31:30] = 2'b00;
            default: if (a[31:30] == 2'b00) a[31:30] = 2'b01;
        endcase
        return a;
    endfunction

    function automatic txn_t mk(input logic [31:0] a, input logic rw, input int rg,
                                input int ws, input logic w16);
        txn_t t;
        t.addr = a;
        t.rw   = rw;
        t.ws   = CW'($urandom);
        t.w16  = NREG'($urandom);
        t.ws[rg*WSW +: WSW] = WSW'(ws);
        t.w16[rg] = w16;
        return t;
    endfunction

    // Drives seq_q as a chain of back-to-back accesses and checks every output each cycle.
    task automatic run_seq(input int ce_mode);
        int i, e, r, wse, cyc;
        logic w16e, start_now, act;
        logic exp_rdy, exp_szrq, exp_err, exp_wen, exp_oen;
        logic [31:0] data;
        logic [NREG-1:0] exp_cen, onehot;
        txn_t cur, nxt;
        i = 0; e = 0; cyc = 0;
        seq_cycles = 0; seq_ready = 0; seq_wen_low = 0; seq_err = 0; seq_szrq = 0;
        seq_first_ready = -1;
        while (i < seq_q.size()) begin
            cur = seq_q[i];
            r = region_of(cur.addr);
            wse = 0; w16e = 1'b0; data = UNMAPPED; onehot = '0;
            if (r >= 0) begin
                wse = int'(cur.ws[r*WSW +: WSW]);
                w16e = cur.w16[r];
                data = rd_val[r];
                onehot[r] = 1'b1;
            end
            start_now = (e == 0) || ((e == wse + 1) && (i + 1 < seq_q.size()));
            if (start_now) begin
                nxt = (e == 0) ? cur : seq_q[i+1];
                BCYSTn = 1'b0; A = nxt.addr; RW = nxt.rw;
                CFG_WS = nxt.ws; CFG_W16 = nxt.w16; CE = 1'b1;
            end else begin
                BCYSTn = 1'b1; A = $urandom;
                CFG_WS = CW'($urandom); CFG_W16 = NREG'($urandom);
                case (ce_mode)
                    0: CE = 1'b1;
                    1: CE = (cyc % 2 == 0);
                    default: CE = 1'($urandom_range(0, 1));
                endcase
            end
            DAn = 1'b0; BEn = 4'($urandom); MRQn = 1'($urandom);
            @(negedge CLK);
            act = (e >= 1) && (e <= wse + 1) && (r >= 0);
            if (e == wse + 1) exp_di = data;
            exp_cen  = act ? ~onehot : '1;
            exp_rdy  = !(e == wse + 1);
            exp_szrq = !((e == wse + 1) && w16e);
            exp_err  = (r < 0) && (e == 1);
            exp_wen  = !(act && !RW && !DAn);
            exp_oen  = !(act && RW && !DAn);
            checks++;
            if (READYn !== exp_rdy) begin
                errors++; $display("FAIL readyn cyc=%0d got=%b exp=%b", cyc, READYn, exp_rdy);
            end
            checks++;
            if (SZRQn !== exp_szrq) begin
                errors++; $display("FAIL szrqn cyc=%0d got=%b exp=%b", cyc, SZRQn, exp_szrq);
            end
            checks++;
            if (CEn !== exp_cen) begin
                errors++; $display("FAIL cen cyc=%0d got=%b exp=%b", cyc, CEn, exp_cen);
            end
            checks++;
            if (ERR !== exp_err) begin
                errors++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, ERR, exp_err);
            end
            checks++;
            if (D_I !== exp_di) begin
                errors++; $display("FAIL d_i cyc=%0d got=%h exp=%h", cyc, D_I, exp_di);
            end
            checks++;
            if (WEn !== exp_wen) begin
                errors++; $display("FAIL wen cyc=%0d got=%b exp=%b", cyc, WEn, exp_wen);
            end
            checks++;
            if (OEn !== exp_oen) begin
                errors++; $display("FAIL oen cyc=%0d got=%b exp=%b", cyc, OEn, exp_oen);
            end
            if (READYn === 1'b0 && CE) seq_ready++;
            if (READYn === 1'b0 && seq_first_ready < 0) seq_first_ready = cyc;
            if (WEn === 1'b0) seq_wen_low++;
            if (ERR === 1'b1 && CE) seq_err++;
            if (SZRQn === 1'b0 && CE) seq_szrq++;
            @(posedge CLK); #1;
            if (CE) begin
                if (start_now && e != 0) begin
                    i++; e = 1;
                end else begin
                    e++;
                    if (e == wse + 2) begin
                        i++; e = 0;
                    end
                end
            end
            cyc++;
            seq_cycles = cyc;
            if (cyc > 400) begin
                checks++; errors++;
                $display("FAIL seq_timeout got=%0d cycles exp<=400", cyc);
                break;
            end
        end
        BCYSTn = 1'b1; DAn = 1'b1; CE = 1'b1;
    endtask

    task automatic test_reset();
        RES = 1'b1; CE = 1'b0; BCYSTn = 1'b0; A = 32'h0; DAn = 1'b0; RW = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        exp_di = UNMAPPED;
        checks++;
        if (READYn !== 1'b1) begin errors++; $display("FAIL rst_readyn got=%b exp=1", READYn); end
        checks++;
        if (SZRQn !== 1'b1) begin errors++; $display("FAIL rst_szrqn got=%b exp=1", SZRQn); end
        checks++;
        if (CEn !== 3'b111) begin errors++; $display("FAIL rst_cen got=%b exp=111", CEn); end
        checks++;
        if (WEn !== 1'b1) begin errors++; $display("FAIL rst_wen got=%b exp=1", WEn); end
        checks++;
        if (OEn !== 1'b1) begin errors++; $display("FAIL rst_oen got=%b exp=1", OEn); end
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", ERR); end
        checks++;
        if (D_I !== UNMAPPED) begin errors++; $display("FAIL rst_d_i got=%h exp=%h", D_I, UNMAPPED); end
        RES = 1'b0; CE = 1'b1; BCYSTn = 1'b1; DAn = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_region0_ws0();
        rd_val[0] = 32'h1234_5678;
        seq_q.delete();
        seq_q.push_back(mk(32'h0000_0040, 1'b1, 0, 0, 1'b0));
        run_seq(0);
        checks++;
        if (seq_first_ready !== 1) begin
            errors++; $display("FAIL r0_latency got=%0d exp=1", seq_first_ready);
        end
        checks++;
        if (D_I !== 32'h1234_5678) begin
            errors++; $display("FAIL r0_data got=%h exp=12345678", D_I);
        end
    endtask

    task automatic test_w16_ws3();
        seq_q.delete();
        seq_q.push_back(mk(32'h1234_5670, 1'b1, 1, 3, 1'b1));
        run_seq(0);
        checks++;
        if (seq_first_ready !== 4) begin
            errors++; $display("FAIL w16_latency got=%0d exp=4", seq_first_ready);
        end
        checks++;
        if (seq_szrq !== 1) begin
            errors++; $display("FAIL w16_szrq_cycles got=%0d exp=1", seq_szrq);
        end
    endtask

    task automatic test_unmapped();
        seq_q.delete();
        seq_q.push_back(mk(32'h4000_0000, 1'b1, 0, 7, 1'b1));
        run_seq(0);
        checks++;
        if (seq_err !== 1) begin errors++; $display("FAIL unmapped_err got=%0d exp=1", seq_err); end
        checks++;
        if (seq_first_ready !== 1) begin
            errors++; $display("FAIL unmapped_latency got=%0d exp=1", seq_first_ready);
        end
        checks++;
        if (D_I !== UNMAPPED) begin errors++; $display("FAIL unmapped_d_i got=%h exp=%h", D_I, UNMAPPED); end
    endtask

    task automatic test_back_to_back();
        seq_q.delete();
        seq_q.push_back(mk(32'h2000_1000, 1'b0, 2, 1, 1'b0));
        seq_q.push_back(mk(32'h0000_0100, 1'b1, 0, 0, 1'b0));
        run_seq(0);
        checks++;
        if (seq_ready !== 2) begin errors++; $display("FAIL b2b_ready_pulses got=%0d exp=2", seq_ready); end
        checks++;
        if (seq_cycles !== 4) begin errors++; $display("FAIL b2b_cycles got=%0d exp=4", seq_cycles); end
        checks++;
        if (seq_wen_low !== 1) begin errors++; $display("FAIL b2b_wen_cycles got=%0d exp=1", seq_wen_low); end
    endtask

    task automatic test_ce_toggle();
        seq_q.delete();
        seq_q.push_back(mk(32'h0000_2000, 1'b1, 0, 2, 1'b0));
        run_seq(1);
        checks++;
        if (seq_first_ready !== 5) begin
            errors++; $display("FAIL ce_latency got=%0d exp=5", seq_first_ready);
        end
        checks++;
        if (seq_cycles !== 7) begin errors++; $display("FAIL ce_cycles got=%0d exp=7", seq_cycles); end
        checks++;
        if (seq_ready !== 1) begin errors++; $display("FAIL ce_ready_pulses got=%0d exp=1", seq_ready); end
    endtask

    task automatic test_reset_mid_wait();
        txn_t t;
        t = mk(32'h1000_0000, 1'b1, 1, 6, 1'b0);
        BCYSTn = 1'b0; A = t.addr; RW = t.rw; CFG_WS = t.ws; CFG_W16 = t.w16; DAn = 1'b0; CE = 1'b1;
        @(posedge CLK); #1;
        BCYSTn = 1'b1;
        @(negedge CLK);
        checks++;
        if (CEn !== 3'b101) begin errors++; $display("FAIL mid_cen got=%b exp=101", CEn); end
        @(posedge CLK); #1;
        RES = 1'b1; CE = 1'b0;
        @(posedge CLK); #1;
        RES = 1'b0; CE = 1'b1;
        exp_di = UNMAPPED;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checks++;
            if (READYn !== 1'b1) begin errors++; $display("FAIL mid_rst_readyn k=%0d got=%b exp=1", k, READYn); end
            checks++;
            if (CEn !== 3'b111) begin errors++; $display("FAIL mid_rst_cen k=%0d got=%b exp=111", k, CEn); end
            checks++;
            if (D_I !== UNMAPPED) begin errors++; $display("FAIL mid_rst_d_i k=%0d got=%h exp=%h", k, D_I, UNMAPPED); end
            @(posedge CLK); #1;
        end
        DAn = 1'b1;
        seq_q.delete();
        seq_q.push_back(mk(32'h1800_0004, 1'b0, 1, 2, 1'b0));
        run_seq(0);
        checks++;
        if (seq_ready !== 1) begin errors++; $display("FAIL post_rst_ready got=%0d exp=1", seq_ready); end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < NREG; r++) rd_val[r] = $urandom;
            n = $urandom_range(1, 3);
            seq_q.delete();
            for (int k = 0; k < n; k++)
                seq_q.push_back(mk(rand_addr(), 1'($urandom), 0, $urandom_range(0, 15), 1'($urandom)));
            run_seq($urandom_range(0, 2));
            checks++;
            if (seq_ready !== n) begin
                errors++; $display("FAIL rand_ready_pulses it=%0d got=%0d exp=%0d", it, seq_ready, n);
            end
        end
    endtask

    initial begin
        RES = 1'b0; CE = 1'b1; BCYSTn = 1'b1; DAn = 1'b1; RW = 1'b1; MRQn = 1'b0;
        A = '0; BEn = '1; CFG_WS = '0; CFG_W16 = '0;
        for (int r = 0; r < NREG; r++) rd_val[r] = $urandom;
        exp_di = UNMAPPED;
        test_reset();
        test_region0_ws0();
        test_w16_ws3();
        test_unmapped();
        test_back_to_back();
        test_ce_toggle();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
